alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 151 +++++++++++++++
 tb/tb_alu_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops return after one cycle; an optional iterative
// shift-add multiplier (ALUOp 9) is compiled in only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             ovf
);

  // state | meaning
  // IDLE  | no result held, ready for a request
  // CALC  | multiplier iterating, one partial product per cycle
  // DONE  | result held on C/zero/ovf until out_ready
`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state, state_nx;
  logic             accept;
  logic             load_res;
  logic [WIDTH-1:0] sum, diff, res;
  logic             res_ovf;
  logic [SHW-1:0]   shamt;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  logic             start_mul;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

  always_comb begin
    sum     = A + B;
    diff    = A - B;
    shamt   = B[SHW-1:0];
    res     = '0;
    res_ovf = 1'b0;
    case (ALUOp)
      4'd0: begin
        res     = sum;
        res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        res     = diff;
        res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: res = A & B;
      4'd3: res = A | B;
      4'd4: res = A >> shamt;
      4'd5: res = $signed(A) >>> shamt;
      4'd6: res = A << shamt;
      4'd7: res[0] = $signed(A) < $signed(B);
      4'd8: res[0] = A < B;
      default: res = '0;  // op 9 lands here too; the multiplier never uses res
    endcase
  end

  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    load_res = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    start_mul = 1'b0;
`endif
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (ALUOp == 4'd9) begin
            start_mul = 1'b1;
            state_nx  = CALC;
          end else
`endif
          begin
            load_res = 1'b1;
            state_nx = DONE;
          end
        end else if ((state == DONE) && out_ready) begin
          state_nx = IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      CALC: if (cnt == CNT_LAST) state_nx = DONE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      C    <= '0;
      zero <= 1'b1;
      ovf  <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      if (load_res) begin
        C    <= res;
        zero <= (res == '0);
        ovf  <= res_ovf;
      end
`ifdef ALU_PIPE_MUL_EN
      if (start_mul) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        // multiplicand walks left, multiplier walks right; counter wraps to 0 on the last step
        acc    <= acc_nx;
        mcand  <= {mcand[WIDTH-2:0], 1'b0};
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
        if (cnt == CNT_LAST) begin
          C    <= acc_nx;
          zero <= (acc_nx == '0);
          ovf  <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes hand-computed results as requests
// are accepted, a negedge monitor checks latency and pops on each output handshake.
module tb_alu_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, out_valid, out_ready, zero, ovf;
  logic [W-1:0]  A, B, C;
  logic [3:0]    ALUOp;

  typedef struct {
    logic [W-1:0] c;
    logic         z;
    logic         o;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   newres = 1'b1;
  int   w;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ec, input logic ez, input logic eo,
                       input int elat, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; ALUOp = op;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.c = ec; e.z = ez; e.o = eo; e.acc = cyc + 1; e.lat = elat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUOp = 4'($urandom_range(0, 15));
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out: C=%0h with nothing expected", C);
      end else begin
        if (newres) begin
          check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
          newres = 1'b0;
        end
        if (out_ready) begin
          check("C", 64'(C), 64'(sb[0].c));
          check("zero", 64'(zero), 64'(sb[0].z));
          check("ovf", 64'(ovf), 64'(sb[0].o));
          void'(sb.pop_front());
          newres = 1'b1;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUOp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_C", 64'(C), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // single-cycle ops, issued back to back
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, w);
    issue(4'd5, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1, w);
    check("b2b_wait", 64'(w), 64'd0);
    issue(4'd4, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 1, w);
    check("b2b_wait", 64'(w), 64'd0);
    issue(4'd6, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0, 1, w);
    issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, w);
    issue(4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, w);
    issue(4'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1, w);
    issue(4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, w);
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, w);
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b0, 1, w);

    // result held while consumer stalls, then handoff with no bubble
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_C", 64'(C), 64'h0000_F000);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1, w);
    check("handoff_wait", 64'(w), 64'd0);

    // multiply; operands scrambled after accept
`ifdef ALU_PIPE_MUL_EN
    issue(4'd9, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, w);
    issue(4'd9, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0, 33, w);
    check("calc_wait", 64'(w > 0), 64'd1);
`else
    issue(4'd9, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 1'b1, 1'b0, 1, w);
`endif

    // reset while busy discards the pending work
`ifdef ALU_PIPE_MUL_EN
    issue(4'd9, 32'h0000_0003, 32'h0000_0003, 32'h0000_0009, 1'b0, 1'b0, 33, w);
    repeat (4) @(negedge clk);
    check("calc_in_ready", 64'(in_ready), 64'd0);
`else
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1, w);
    @(negedge clk);
    check("pend_in_ready", 64'(in_ready), 64'd0);
`endif
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    newres = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_C", 64'(C), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd1);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    issue(4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1, w);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
